avalon_timer_master: RTL and testbench



---
 rtl/avalon_timer_pkg.sv | 44 ++++
 rtl/avalon_timer_master.sv | 205 ++++++++++++++++++++
 tb/tb_avalon_timer_master.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_timer_pkg.sv
// ----------------------------------------------------------------------------
// avalon_timer_pkg
// Shared definitions for the interval-timer Avalon-MM initiator:
//   - slave register addresses
//   - control register bit positions
//   - initiator FSM state encoding
//   - helper to build a one-hot control word
// ----------------------------------------------------------------------------
package avalon_timer_pkg;

    // Timer slave register map
    localparam logic [2:0] STATUS  = 3'd0;
    localparam logic [2:0] CONTROL = 3'd1;
    localparam logic [2:0] PERIODL = 3'd2;
    localparam logic [2:0] PERIODH = 3'd3;
    localparam logic [2:0] SNAPL   = 3'd4;
    localparam logic [2:0] SNAPH   = 3'd5;

    // Control register bit positions
    localparam int unsigned ITO   = 0;
    localparam int unsigned CONT  = 1;
    localparam int unsigned START = 2;
    localparam int unsigned STOP  = 3;

    typedef enum logic [3:0] {
        StIdle,
        StWrPl,
        StWrPh,
        StWrCtl,
        StArmed,
        StClrSt,
        StWrStop,
        StSnapWr,
        StSnapLa,
        StSnapLd,
        StSnapHa,
        StSnapHd
    } state_e;

    function automatic logic [15:0] ctl_bit(input int unsigned pos);
        return 16'(1) << pos;
    endfunction

endpackage

// File: rtl/avalon_timer_master.sv
// ----------------------------------------------------------------------------
// avalon_timer_master
// Avalon-MM initiator that programs and services a 16-bit interval timer.
// Local requests (configure/start, stop, snapshot) become register-level
// write/read sequences; timer interrupts are acknowledged by clearing the
// status register and reported as a one-cycle tick.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_reset          synchronous active-high reset
//   i_cfg_start      pulse: load period/mode and start (accepted in idle only)
//   i_cfg_period     32-bit timer period, sampled with an accepted start
//   i_cfg_continuous 1 = continuous, 0 = one-shot, sampled with start
//   i_cfg_stop       pulse: stop the timer (accepted when armed only)
//   i_snap_req       pulse: snapshot the counter (accepted when armed only)
//   o_address        Avalon address
//   o_chipselect     Avalon chipselect
//   o_write_n        Avalon write strobe, active low
//   o_writedata      Avalon write data
//   i_readdata       slave read data, valid the cycle after the address cycle
//   i_irq            slave interrupt, level
//   o_busy           high whenever not idle
//   o_running        timer started and not yet stopped/completed
//   o_tick           one-cycle pulse per serviced timeout
//   o_tick_count     serviced-timeout count, cleared on each accepted start
//   o_snap_value     last 32-bit snapshot
//   o_snap_valid     one-cycle pulse when o_snap_value updates
// ----------------------------------------------------------------------------
module avalon_timer_master
    import avalon_timer_pkg::*;
#(
    parameter int unsigned TICK_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cfg_start,
    input  logic [31:0]       i_cfg_period,
    input  logic              i_cfg_continuous,
    input  logic              i_cfg_stop,
    input  logic              i_snap_req,
    output logic [2:0]        o_address,
    output logic              o_chipselect,
    output logic              o_write_n,
    output logic [15:0]       o_writedata,
    input  logic [15:0]       i_readdata,
    input  logic              i_irq,
    output logic              o_busy,
    output logic              o_running,
    output logic              o_tick,
    output logic [TICK_W-1:0] o_tick_count,
    output logic [31:0]       o_snap_value,
    output logic              o_snap_valid
);

    state_e              r_state;
    state_e              w_state_d;
    logic [31:0]         r_period;
    logic                r_cont;
    logic                r_running;
    logic                r_tick;
    logic [TICK_W-1:0]   r_tick_count;
    logic [15:0]         r_snap_lo;
    logic [31:0]         r_snap_value;
    logic                r_snap_valid;
    logic                r_irq_mask;
    logic                w_irq_eff;

    logic [2:0]          w_address;
    logic                w_chipselect;
    logic                w_write_n;
    logic [15:0]         w_writedata;

    // The slave's status clears one edge after our write, so irq can still
    // read high in the cycle following CLR_ST; ignore it for that one cycle.
    assign w_irq_eff = i_irq & ~r_irq_mask;

    always_comb begin
        w_state_d    = r_state;
        w_chipselect = 1'b0;
        w_write_n    = 1'b1;
        w_address    = STATUS;
        w_writedata  = '0;
        unique case (r_state)
            StIdle: begin
                if (i_cfg_start) w_state_d = StWrPl;
            end
            StWrPl: begin
                w_chipselect = 1'b1;
                w_write_n    = 1'b0;
                w_address    = PERIODL;
                w_writedata  = r_period[15:0];
                w_state_d    = StWrPh;
            end
            StWrPh: begin
                w_chipselect = 1'b1;
                w_write_n    = 1'b0;
                w_address    = PERIODH;
                w_writedata  = r_period[31:16];
                w_state_d    = StWrCtl;
            end
            StWrCtl: begin
                w_chipselect = 1'b1;
                w_write_n    = 1'b0;
                w_address    = CONTROL;
                w_writedata  = ctl_bit(START) | ctl_bit(ITO) | (r_cont ? ctl_bit(CONT) : 16'h0);
                w_state_d    = StArmed;
            end
            StArmed: begin
                // Fixed priority; losing requests are dropped.
                if (w_irq_eff)       w_state_d = StClrSt;
                else if (i_cfg_stop) w_state_d = StWrStop;
                else if (i_snap_req) w_state_d = StSnapWr;
            end
            StClrSt: begin
                w_chipselect = 1'b1;
                w_write_n    = 1'b0;
                w_address    = STATUS;
                w_state_d    = r_cont ? StArmed : StIdle;
            end
            StWrStop: begin
                w_chipselect = 1'b1;
                w_write_n    = 1'b0;
                w_address    = CONTROL;
                w_writedata  = ctl_bit(STOP);
                w_state_d    = StIdle;
            end
            StSnapWr: begin
                // Any write to SNAPL latches the running counter in the slave.
                w_chipselect = 1'b1;
                w_write_n    = 1'b0;
                w_address    = SNAPL;
                w_state_d    = StSnapLa;
            end
            StSnapLa: begin
                w_chipselect = 1'b1;
                w_address    = SNAPL;
                w_state_d    = StSnapLd;
            end
            StSnapLd: begin
                w_state_d = StSnapHa;
            end
            StSnapHa: begin
                w_chipselect = 1'b1;
                w_address    = SNAPH;
                w_state_d    = StSnapHd;
            end
            StSnapHd: begin
                w_state_d = StArmed;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_period     <= '0;
            r_cont       <= 1'b0;
            r_running    <= 1'b0;
            r_tick       <= 1'b0;
            r_tick_count <= '0;
            r_snap_lo    <= '0;
            r_snap_value <= '0;
            r_snap_valid <= 1'b0;
            r_irq_mask   <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_tick       <= 1'b0;
            r_snap_valid <= 1'b0;
            r_irq_mask   <= (r_state == StClrSt);

            if (r_state == StIdle && i_cfg_start) begin
                r_period     <= i_cfg_period;
                r_cont       <= i_cfg_continuous;
                r_tick_count <= '0;
            end
            if (r_state == StWrCtl) r_running <= 1'b1;
            if (r_state == StClrSt) begin
                r_tick       <= 1'b1;
                r_tick_count <= r_tick_count + TICK_W'(1);
                if (!r_cont) r_running <= 1'b0;
            end
            if (r_state == StWrStop) r_running <= 1'b0;
            if (r_state == StSnapLd) r_snap_lo <= i_readdata;
            if (r_state == StSnapHd) begin
                r_snap_value <= {i_readdata, r_snap_lo};
                r_snap_valid <= 1'b1;
            end
        end
    end

    assign o_address    = w_address;
    assign o_chipselect = w_chipselect;
    assign o_write_n    = w_write_n;
    assign o_writedata  = w_writedata;
    assign o_busy       = (r_state != StIdle);
    assign o_running    = r_running;
    assign o_tick       = r_tick;
    assign o_tick_count = r_tick_count;
    assign o_snap_value = r_snap_value;
    assign o_snap_valid = r_snap_valid;

endmodule

// File: tb/tb_avalon_timer_master.sv
// ----------------------------------------------------------------------------
// tb_avalon_timer_master
// Directed bench for avalon_timer_master. A narrow tick counter (TW=3) makes
// the modulo wrap reachable quickly. Inputs change and outputs are checked on
// the falling edge; the DUT works on the rising edge.
// ----------------------------------------------------------------------------
module tb_avalon_timer_master;

    localparam int unsigned TW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_start;
    logic [31:0]   cfg_period;
    logic          cfg_continuous;
    logic          cfg_stop;
    logic          snap_req;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [15:0]   writedata;
    logic [15:0]   readdata;
    logic          irq;
    logic          busy;
    logic          running;
    logic          tick;
    logic [TW-1:0] tick_count;
    logic [31:0]   snap_value;
    logic          snap_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avalon_timer_master #(.TICK_W(TW)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_cfg_start      (cfg_start),
        .i_cfg_period     (cfg_period),
        .i_cfg_continuous (cfg_continuous),
        .i_cfg_stop       (cfg_stop),
        .i_snap_req       (snap_req),
        .o_address        (address),
        .o_chipselect     (chipselect),
        .o_write_n        (write_n),
        .o_writedata      (writedata),
        .i_readdata       (readdata),
        .i_irq            (irq),
        .o_busy           (busy),
        .o_running        (running),
        .o_tick           (tick),
        .o_tick_count     (tick_count),
        .o_snap_value     (snap_value),
        .o_snap_valid     (snap_valid)
    );

    // Registered slave read port: data appears the cycle after the address
    // cycle; anything not read returns a marker so mistimed captures show.
    always @(posedge clk) begin
        if (chipselect && write_n && address == 3'd4)      readdata <= 16'h1234;
        else if (chipselect && write_n && address == 3'd5) readdata <= 16'h0005;
        else                                               readdata <= 16'hDEAD;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input string tag, input logic cs, input logic wn,
                       input logic [2:0] a, input logic [15:0] wd);
        chk({tag, ".cs"},   32'(chipselect), 32'(cs));
        chk({tag, ".wn"},   32'(write_n),    32'(wn));
        chk({tag, ".addr"}, 32'(address),    32'(a));
        chk({tag, ".wd"},   32'(writedata),  32'(wd));
    endtask

    initial begin
        reset = 1'b1; cfg_start = 1'b0; cfg_period = '0; cfg_continuous = 1'b0;
        cfg_stop = 1'b0; snap_req = 1'b0; irq = 1'b0;
        @(negedge clk);
        step();
        step();
        reset = 1'b0;

        // Reset state
        bus("rst", 1'b0, 1'b1, 3'd0, 16'h0);
        chk("rst.busy",    32'(busy),       32'h0);
        chk("rst.running", 32'(running),    32'h0);
        chk("rst.tick",    32'(tick),       32'h0);
        chk("rst.tcnt",    32'(tick_count), 32'h0);
        chk("rst.sval",    snap_value,      32'h0);
        chk("rst.svalid",  32'(snap_valid), 32'h0);

        // Continuous configuration
        cfg_start = 1'b1; cfg_period = 32'h0001_86A0; cfg_continuous = 1'b1;
        step();
        cfg_start = 1'b0; cfg_period = 32'hFFFF_FFFF; cfg_continuous = 1'b0;
        bus("cfg.pl", 1'b1, 1'b0, 3'd2, 16'h86A0);
        chk("cfg.pl.busy", 32'(busy), 32'h1);
        step();
        bus("cfg.ph", 1'b1, 1'b0, 3'd3, 16'h0001);
        step();
        bus("cfg.ctl", 1'b1, 1'b0, 3'd1, 16'h0007);
        chk("cfg.ctl.running", 32'(running), 32'h0);
        step();
        bus("cfg.armed", 1'b0, 1'b1, 3'd0, 16'h0);
        chk("cfg.running", 32'(running), 32'h1);

        // Irq service with stale irq in the following cycle
        irq = 1'b1;
        step();
        bus("irq.clr", 1'b1, 1'b0, 3'd0, 16'h0);
        chk("irq.clr.tick", 32'(tick), 32'h0);
        step();
        chk("irq.tick",    32'(tick),       32'h1);
        chk("irq.tcnt",    32'(tick_count), 32'h1);
        chk("irq.running", 32'(running),    32'h1);
        bus("irq.armed", 1'b0, 1'b1, 3'd0, 16'h0);
        step();
        irq = 1'b0;
        bus("irq.stale", 1'b0, 1'b1, 3'd0, 16'h0);
        chk("irq.stale.tick", 32'(tick),       32'h0);
        chk("irq.stale.tcnt", 32'(tick_count), 32'h1);

        // Snapshot
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        bus("snap.wr", 1'b1, 1'b0, 3'd4, 16'h0);
        step();
        bus("snap.la", 1'b1, 1'b1, 3'd4, 16'h0);
        step();
        bus("snap.ld", 1'b0, 1'b1, 3'd0, 16'h0);
        chk("snap.ld.valid", 32'(snap_valid), 32'h0);
        step();
        bus("snap.ha", 1'b1, 1'b1, 3'd5, 16'h0);
        step();
        bus("snap.hd", 1'b0, 1'b1, 3'd0, 16'h0);
        chk("snap.hd.valid", 32'(snap_valid), 32'h0);
        step();
        chk("snap.valid", 32'(snap_valid), 32'h1);
        chk("snap.value", snap_value,      32'h0005_1234);
        chk("snap.busy",  32'(busy),       32'h1);
        step();
        chk("snap.valid.off", 32'(snap_valid), 32'h0);

        // Simultaneous irq/stop/snap: irq wins, others dropped
        irq = 1'b1; cfg_stop = 1'b1; snap_req = 1'b1;
        step();
        cfg_stop = 1'b0; snap_req = 1'b0;
        bus("prio.clr", 1'b1, 1'b0, 3'd0, 16'h0);
        step();
        chk("prio.tick", 32'(tick),       32'h1);
        chk("prio.tcnt", 32'(tick_count), 32'h2);
        step();
        irq = 1'b0;
        bus("prio.drop1", 1'b0, 1'b1, 3'd0, 16'h0);
        step();
        bus("prio.drop2", 1'b0, 1'b1, 3'd0, 16'h0);
        chk("prio.running", 32'(running),    32'h1);
        chk("prio.svalid",  32'(snap_valid), 32'h0);

        // Stop
        cfg_stop = 1'b1;
        step();
        cfg_stop = 1'b0;
        bus("stop.wr", 1'b1, 1'b0, 3'd1, 16'h0008);
        step();
        bus("stop.idle", 1'b0, 1'b1, 3'd0, 16'h0);
        chk("stop.running", 32'(running), 32'h0);
        chk("stop.busy",    32'(busy),    32'h0);

        // One-shot with period 0
        cfg_start = 1'b1; cfg_period = 32'h0; cfg_continuous = 1'b0;
        step();
        cfg_start = 1'b0; cfg_period = 32'hA5A5_5A5A; cfg_continuous = 1'b1;
        bus("os.pl", 1'b1, 1'b0, 3'd2, 16'h0);
        chk("os.tcnt.clr", 32'(tick_count), 32'h0);
        step();
        bus("os.ph", 1'b1, 1'b0, 3'd3, 16'h0);
        step();
        bus("os.ctl", 1'b1, 1'b0, 3'd1, 16'h0005);
        step();
        chk("os.running", 32'(running), 32'h1);
        irq = 1'b1;
        step();
        bus("os.clr", 1'b1, 1'b0, 3'd0, 16'h0);
        step();
        chk("os.tick",     32'(tick),       32'h1);
        chk("os.tcnt",     32'(tick_count), 32'h1);
        chk("os.running0", 32'(running),    32'h0);
        chk("os.busy0",    32'(busy),       32'h0);
        step();
        bus("os.ign1", 1'b0, 1'b1, 3'd0, 16'h0);
        chk("os.ign1.tick", 32'(tick), 32'h0);
        step();
        bus("os.ign2", 1'b0, 1'b1, 3'd0, 16'h0);
        chk("os.ign2.busy", 32'(busy), 32'h0);
        irq = 1'b0;

        // tick_count wraps modulo 2^TW
        cfg_start = 1'b1; cfg_period = 32'h10; cfg_continuous = 1'b1;
        step();
        cfg_start = 1'b0;
        step();
        step();
        step();
        for (int i = 1; i <= 8; i++) begin
            irq = 1'b1;
            step();
            step();
            irq = 1'b0;
            step();
            chk($sformatf("wrap.tcnt%0d", i), 32'(tick_count), 32'(i % 8));
        end

        // Reset in the middle of a snapshot
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        step();
        step();
        step();
        bus("rsnap.ha", 1'b1, 1'b1, 3'd5, 16'h0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus("rsnap.idle", 1'b0, 1'b1, 3'd0, 16'h0);
        chk("rsnap.busy",   32'(busy),       32'h0);
        chk("rsnap.sval",   snap_value,      32'h0);
        chk("rsnap.svalid", 32'(snap_valid), 32'h0);
        step();
        chk("rsnap.svalid1", 32'(snap_valid), 32'h0);
        step();
        chk("rsnap.svalid2", 32'(snap_valid), 32'h0);
        chk("rsnap.sval2",   snap_value,      32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
